// File: rtl/tick_div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tick_div_ctrl_pkg
// Shared definitions for the tick divider: the default counter width, the
// default half-period after reset, and the two-state FSM encoding.
// -----------------------------------------------------------------------------
package tick_div_ctrl_pkg;

    // Counter / half-period width (26 bits holds 25_000_000).
    localparam int CNT_W        = 26;
    // Half-period after reset: 1 Hz square wave from a 50 MHz clock.
    localparam int DEFAULT_HALF = 25_000_000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tick_div_ctrl_if.sv
// -----------------------------------------------------------------------------
// tick_div_ctrl_if
// Configuration handshake carrying a new half-period into the divider.
//   cfg_valid : source offers cfg_half
//   cfg_half  : requested half-period in clk cycles (0 is treated as 1)
//   cfg_ready : divider can take a configuration (no value pending)
// Modports: master = configuration source, slave = tick_div_ctrl.
// -----------------------------------------------------------------------------
interface tick_div_ctrl_if #(
    parameter int CNT_W = tick_div_ctrl_pkg::CNT_W
) ();

    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_half;
    logic             cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_half,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_half,
        output cfg_ready
    );

endinterface

// File: rtl/tick_div_ctrl_half_period_counter.sv
// -----------------------------------------------------------------------------
// half_period_counter
// Counts 1..limit while run is high and flags the wrap cycle (cnt == limit).
// Ports:
//   clk   : clock
//   clear : force the count back to 1 (reset / not running)
//   run   : count this cycle
//   limit : half-period currently in effect (always >= 1)
//   wrap  : high in the cycle the count reaches limit; count reloads to 1
// -----------------------------------------------------------------------------
module half_period_counter #(
    parameter int CNT_W = tick_div_ctrl_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             run,
    input  logic [CNT_W-1:0] limit,
    output logic             wrap
);
    import tick_div_ctrl_pkg::*;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reloading at limit keeps cnt <= limit, so it never rolls over 2^CNT_W.
    assign wrap = run && !clear && (cnt_q == limit);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = CNT_W'(1);
        end else if (wrap) begin
            cnt_d = CNT_W'(1);
        end else if (run) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/tick_div_ctrl.sv
// -----------------------------------------------------------------------------
// tick_div_ctrl
// Programmable clock divider producing a square wave q with period
// 2*cur_half clk cycles, plus a one-cycle tick on every q edge. A new
// half-period arrives over a one-deep valid/ready handshake and is applied
// only at a wrap (or immediately while idle) so q never shows a short or
// stretched half-period.
// Ports:
//   clk      : clock, all logic on posedge
//   rst      : synchronous active-high reset
//   en       : 1 = divide, 0 = stop (partial count discarded, q forced 0)
//   cfg      : configuration handshake (slave side)
//   q        : divided square wave
//   tick     : one-cycle pulse aligned with each new q value
//   cur_half : half-period currently in effect
// -----------------------------------------------------------------------------
module tick_div_ctrl #(
    parameter int CNT_W        = tick_div_ctrl_pkg::CNT_W,
    parameter int DEFAULT_HALF = tick_div_ctrl_pkg::DEFAULT_HALF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    tick_div_ctrl_if.slave   cfg,
    output logic             q,
    output logic             tick,
    output logic [CNT_W-1:0] cur_half
);
    import tick_div_ctrl_pkg::*;

    localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF);

    // A zero half-period would never wrap; clamp it to the minimum of 1.
    function automatic logic [CNT_W-1:0] sat_half(input logic [CNT_W-1:0] h);
        return (h == '0) ? CNT_W'(1) : h;
    endfunction

    state_t           state_q, state_d;
    logic             q_q, q_d;
    logic             tick_q, tick_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cur_half_q, cur_half_d;
    logic [CNT_W-1:0] pend_half_q, pend_half_d;

    logic run;
    logic clear;
    logic wrap;
    logic accept;
    logic apply;

    // Counting happens only in RUN with en still high; the cycle en drops is
    // the RUN->IDLE cycle and already clears the count.
    assign run    = (state_q == RUN) && en;
    assign clear  = rst || !run;
    // accept and apply are mutually exclusive (accept needs pend_q=0), so a
    // handshake on a wrap cycle waits for the following wrap.
    assign accept = cfg.cfg_valid && !pend_q;
    assign apply  = pend_q && ((state_q == IDLE) || wrap);

    half_period_counter #(
        .CNT_W (CNT_W)
    ) u_half_period_counter (
        .clk   (clk),
        .clear (clear),
        .run   (run),
        .limit (cur_half_q),
        .wrap  (wrap)
    );

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        tick_d      = wrap;
        cur_half_d  = cur_half_q;
        pend_d      = pend_q;
        pend_half_d = pend_half_q;

        case (state_q)
            IDLE:    if (en)  state_d = RUN;
            RUN:     if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (!run) begin
            q_d = 1'b0;
        end else if (wrap) begin
            q_d = ~q_q;
        end

        if (apply) begin
            cur_half_d = pend_half_q;
            pend_d     = 1'b0;
        end
        if (accept) begin
            pend_d      = 1'b1;
            pend_half_d = sat_half(cfg.cfg_half);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            q_q         <= 1'b0;
            tick_q      <= 1'b0;
            cur_half_q  <= RST_HALF;
            pend_q      <= 1'b0;
            pend_half_q <= RST_HALF;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            tick_q      <= tick_d;
            cur_half_q  <= cur_half_d;
            pend_q      <= pend_d;
            pend_half_q <= pend_half_d;
        end
    end

    assign cfg.cfg_ready = !pend_q;
    assign q             = q_q;
    assign tick          = tick_q;
    assign cur_half      = cur_half_q;

endmodule

// File: tb/tb_tick_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tick_div_ctrl
// Directed bench for tick_div_ctrl with DEFAULT_HALF = 5 and CNT_W = 8.
// Inputs change and outputs are sampled just after the falling edge.
// -----------------------------------------------------------------------------
module tb_tick_div_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         en;
    logic         q_w;
    logic         tick_w;
    logic [W-1:0] cur_half_w;

    int n_vec;
    int n_err;

    tick_div_ctrl_if #(.CNT_W(W)) cfg_if ();

    tick_div_ctrl #(
        .CNT_W        (W),
        .DEFAULT_HALF (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cfg      (cfg_if),
        .q        (q_w),
        .tick     (tick_w),
        .cur_half (cur_half_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int tog [5];
        int nt;
        logic exp_tick;

        tog    = '{5, 10, 15, 18, 21};
        n_vec  = 0;
        n_err  = 0;
        rst    = 1'b1;
        en     = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_half  = '0;
        step();
        step();

        // Reset state
        chk("rst_q",     32'(q_w),               0);
        chk("rst_tick",  32'(tick_w),            0);
        chk("rst_half",  32'(cur_half_w),        5);
        chk("rst_ready", 32'(cfg_if.cfg_ready),  1);

        // Enable: edge 0 enters RUN, toggles expected at edges 5 and 10,
        // then cfg 3 accepted at edge 13, second offer (7) ignored at 14,
        // applied at wrap 15, then toggles at 18 and 21; en drops before 24.
        rst = 1'b0;
        en  = 1'b1;
        step();
        chk("run0_q", 32'(q_w), 0);
        for (int k = 1; k <= 23; k++) begin
            step();
            nt = 0;
            exp_tick = 1'b0;
            for (int t = 0; t < 5; t++) begin
                if (tog[t] <= k) nt++;
                if (tog[t] == k) exp_tick = 1'b1;
            end
            chk($sformatf("q_k%0d", k),     32'(q_w),    32'(nt % 2));
            chk($sformatf("tick_k%0d", k),  32'(tick_w), 32'(exp_tick));
            chk($sformatf("ready_k%0d", k), 32'(cfg_if.cfg_ready),
                (k == 13 || k == 14) ? 32'd0 : 32'd1);
            chk($sformatf("half_k%0d", k),  32'(cur_half_w), (k < 15) ? 32'd5 : 32'd3);
            if (k == 12) begin
                cfg_if.cfg_valid = 1'b1;
                cfg_if.cfg_half  = 8'd3;
            end
            if (k == 13) begin
                cfg_if.cfg_valid = 1'b1;
                cfg_if.cfg_half  = 8'd7;
            end
            if (k == 14) cfg_if.cfg_valid = 1'b0;
            if (k == 23) en = 1'b0;
        end

        // en dropped at cnt=3 while q=1
        step();
        chk("stop_q",     32'(q_w),              0);
        chk("stop_tick",  32'(tick_w),           0);
        chk("stop_half",  32'(cur_half_w),       3);
        chk("stop_ready", 32'(cfg_if.cfg_ready), 1);
        step();
        step();
        chk("idle_q", 32'(q_w), 0);

        // Re-enable: first toggle 3 cycles after entering RUN
        en = 1'b1;
        step();
        for (int r = 1; r <= 3; r++) begin
            step();
            chk($sformatf("re_q%0d", r),    32'(q_w),    (r == 3) ? 32'd1 : 32'd0);
            chk($sformatf("re_tick%0d", r), 32'(tick_w), (r == 3) ? 32'd1 : 32'd0);
        end

        // cfg_half = 0 accepted in IDLE, applied next cycle as 1
        en = 1'b0;
        step();
        chk("idle2_q", 32'(q_w), 0);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_half  = 8'd0;
        step();
        chk("zero_ready0", 32'(cfg_if.cfg_ready), 0);
        chk("zero_half0",  32'(cur_half_w),       3);
        cfg_if.cfg_valid = 1'b0;
        step();
        chk("zero_half1",  32'(cur_half_w),       1);
        chk("zero_ready1", 32'(cfg_if.cfg_ready), 1);
        en = 1'b1;
        step();
        for (int j = 1; j <= 4; j++) begin
            step();
            chk($sformatf("h1_q%0d", j),    32'(q_w),    32'(j % 2));
            chk($sformatf("h1_tick%0d", j), 32'(tick_w), 1);
        end

        // Pending config with q=1, then reset (cfg_valid held during reset)
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_half  = 8'd9;
        step();
        chk("pre_rst_q",     32'(q_w),              1);
        chk("pre_rst_ready", 32'(cfg_if.cfg_ready), 0);
        rst = 1'b1;
        step();
        chk("rst2_q",     32'(q_w),              0);
        chk("rst2_tick",  32'(tick_w),           0);
        chk("rst2_half",  32'(cur_half_w),       5);
        chk("rst2_ready", 32'(cfg_if.cfg_ready), 1);
        rst = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        step();
        for (int j = 1; j <= 5; j++) begin
            step();
            chk($sformatf("post_q%0d", j), 32'(q_w), (j == 5) ? 32'd1 : 32'd0);
        end
        chk("post_half", 32'(cur_half_w), 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tick_div_ctrl.md
TICK_DIV_CTRL -- requirements
Module: tick_div_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 26, the counter and half-period width.
REQ-002 SHALL have parameter DEFAULT_HALF, default 25_000_000, the half-period in clk cycles after reset (1 Hz output at 50 MHz clk).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit: run enable; 1 = divide, 0 = stop.
REQ-006 SHALL have port cfg_valid, input, 1 bit: a new half-period is offered on cfg_half.
REQ-007 SHALL have port cfg_half, input, CNT_W bits: the requested half-period in clk cycles.
REQ-008 SHALL have port cfg_ready, output, 1 bit: the block can accept a configuration.
REQ-009 SHALL have port q, output, 1 bit: the divided square wave.
REQ-010 SHALL have port tick, output, 1 bit: a one-cycle pulse coincident with every q toggle.
REQ-011 SHALL have port cur_half, output, CNT_W bits: the half-period currently in effect.

Function
REQ-012 SHALL implement a two-state FSM with states IDLE and RUN.
REQ-013 IDLE->RUN SHALL occur on the first cycle with en=1; RUN->IDLE SHALL occur on the first cycle with en=0.
REQ-014 In IDLE: counter cnt SHALL be held at 1, q SHALL be held at 0, and tick SHALL be 0.
REQ-015 In RUN when cnt != cur_half: cnt SHALL increment by 1 and q SHALL hold.
REQ-016 In RUN when cnt == cur_half, the wrap cycle: q SHALL invert, cnt SHALL load 1, and tick SHALL be 1 in the following cycle, aligned with the new q value.
REQ-017 q period SHALL be exactly 2*cur_half clk cycles, and the first toggle SHALL occur cur_half cycles after entering RUN.
REQ-018 cfg_ready SHALL equal NOT pend, where pend is a one-deep pending-config flag.
REQ-019 A handshake (cfg_valid AND cfg_ready) SHALL latch cfg_half into pend_half and set pend.
REQ-020 cfg_half = 0 SHALL be stored as 1, so the minimum half-period is 1 and q toggles every cycle.
REQ-021 In RUN, pend_half SHALL be applied to cur_half only on a wrap cycle, clearing pend, so no truncated or stretched half-period ever appears on q.
REQ-022 In IDLE, a pending value SHALL be applied on the next cycle.
REQ-023 A handshake in the same cycle as a wrap SHALL NOT affect that wrap; its value SHALL be applied at the next wrap.
REQ-024 A pending value and a wrap in the same cycle SHALL both take effect: cur_half<=pend_half, cnt<=1, q inverts.
REQ-025 cfg_valid while cfg_ready=0 SHALL be ignored; the source holds its data until the handshake.
REQ-026 cnt SHALL never exceed cur_half, and no counter wrap-around at 2^CNT_W SHALL occur.
REQ-027 en dropping mid-period SHALL discard the partial count (cnt<=1, q<=0) but SHALL retain cur_half and any pending value.

Reset
REQ-028 While rst=1 on a clock edge, the block SHALL set: state=IDLE, cnt=1, q=0, tick=0, cur_half=DEFAULT_HALF, pend=0, pend_half=DEFAULT_HALF, cfg_ready=1.
REQ-029 rst SHALL override en and cfg_valid in the same cycle.
REQ-030 Reset mid-period or with a pending configuration SHALL discard both.

Structure
REQ-031 A shared package SHALL hold CNT_W, DEFAULT_HALF, and the FSM state encoding (IDLE, RUN).
REQ-032 The block SHALL contain one sub-module, half_period_counter, holding cnt and the wrap compare, with inputs clear, run and limit, and output wrap.
REQ-033 The FSM, configuration handshake and q/tick registers SHALL live in tick_div_ctrl.

Verification
REQ-034 Scenario: rst then en=1, DEFAULT_HALF overridden to 5 -> q rises at cycle 5, falls at cycle 10, tick high one cycle at each edge.
REQ-035 Scenario: cfg_half=3 accepted mid-period with cur_half=5 -> the current half-period completes at 5, subsequent half-periods are 3, and cfg_ready returns to 1 at the wrap.
REQ-036 Scenario: second cfg_valid while pend=1 -> cfg_ready=0, value ignored, first value applied.
REQ-037 Scenario: cfg_half=0 -> cur_half=1, q toggles every cycle, tick constant 1.
REQ-038 Scenario: en low at cnt=3 then high -> q=0, and the first toggle comes cur_half cycles after en rises.
REQ-039 Scenario: rst asserted with pend=1 and q=1 -> next cycle q=0, cur_half=DEFAULT_HALF, cfg_ready=1.
